// File: rtl/equeue_ls_fifo.sv
// In-order load/store issue queue: holds dispatched memory ops, snoops the CDB for
// missing base/store-data operands, issues the head to memory and returns load data on the CDB.
module equeue_ls_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              dispatch_en,
    input  logic              dispatch_is_store,
    input  logic [15:0]       dispatch_imm,
    input  logic [DATA_W-1:0] dispatch_rs_data,
    input  logic [TAG_W-1:0]  dispatch_rs_tag,
    input  logic              dispatch_rsvalid,
    input  logic [DATA_W-1:0] dispatch_rt_data,
    input  logic [TAG_W-1:0]  dispatch_rt_tag,
    input  logic              dispatch_rtvalid,
    input  logic [TAG_W-1:0]  dispatch_rd_tag,
    output logic              dispatch_ready,
    input  logic              snoop_valid,
    input  logic [TAG_W-1:0]  snoop_tag,
    input  logic [DATA_W-1:0] snoop_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cdb_valid,
    output logic [DATA_W-1:0] cdb_data,
    output logic [TAG_W-1:0]  cdb_tag,
    input  logic              cdb_grant,
    output logic              cdb_branch,
    output logic              cdb_branch_taken
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_MEM, S_CDB} state_t;
    state_t state, state_nxt;

    logic [PTR_W-1:0]  head, tail;
    logic [CNT_W-1:0]  count;
    logic [DEPTH-1:0]  e_occ, e_st, e_rs_vld, e_rt_vld;
    logic [DATA_W-1:0] e_rs_data [DEPTH];
    logic [DATA_W-1:0] e_rt_data [DEPTH];
    logic [TAG_W-1:0]  e_rs_tag  [DEPTH];
    logic [TAG_W-1:0]  e_rt_tag  [DEPTH];
    logic [TAG_W-1:0]  e_rd_tag  [DEPTH];
    logic signed [15:0] e_imm    [DEPTH];

    logic [DEPTH-1:0]  rs_cap, rt_cap;
    logic              disp_rs_cap, disp_rt_cap;
    logic              do_push, do_pop, do_issue, do_load_done, head_rdy;

    function automatic logic [DATA_W-1:0] calc_addr(input logic [DATA_W-1:0] base,
                                                    input logic signed [15:0] imm);
        logic signed [DATA_W-1:0] off;
        off = DATA_W'(imm);
        return base + off;
    endfunction

    assign dispatch_ready   = (count != FULL_CNT);
    assign do_push          = dispatch_en && dispatch_ready;
    assign cdb_branch       = 1'b0;
    assign cdb_branch_taken = 1'b0;

    assign disp_rs_cap = snoop_valid && !dispatch_rsvalid && (dispatch_rs_tag == snoop_tag);
    assign disp_rt_cap = snoop_valid && !dispatch_rtvalid && (dispatch_rt_tag == snoop_tag);
    assign head_rdy    = (count != '0) && e_rs_vld[head] && (!e_st[head] || e_rt_vld[head]);

    always_comb begin
        rs_cap = '0;
        rt_cap = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rs_cap[i] = snoop_valid && e_occ[i] && !e_rs_vld[i] && (e_rs_tag[i] == snoop_tag);
            rt_cap[i] = snoop_valid && e_occ[i] && !e_rt_vld[i] && (e_rt_tag[i] == snoop_tag);
        end
    end

    always_comb begin
        state_nxt    = state;
        do_issue     = 1'b0;
        do_pop       = 1'b0;
        do_load_done = 1'b0;
        case (state)
            S_IDLE: if (head_rdy) begin
                state_nxt = S_MEM;
                do_issue  = 1'b1;
            end
            S_MEM: if (mem_ack) begin
                if (e_st[head]) begin
                    do_pop    = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    do_load_done = 1'b1;
                    state_nxt    = S_CDB;
                end
            end
            S_CDB: if (cdb_grant) begin
                do_pop    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) state <= S_IDLE;
        else              state <= state_nxt;
    end

    // Queue bookkeeping: pointers, occupancy and operand-valid bits
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            e_occ    <= '0;
            e_rs_vld <= '0;
            e_rt_vld <= '0;
        end else begin
            if (do_push) tail <= tail + 1'b1;
            if (do_pop)  head <= head + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                if (do_push && tail == PTR_W'(i)) begin
                    e_occ[i]    <= 1'b1;
                    e_rs_vld[i] <= dispatch_rsvalid || disp_rs_cap;
                    e_rt_vld[i] <= dispatch_rtvalid || disp_rt_cap;
                end else begin
                    if (do_pop && head == PTR_W'(i)) e_occ[i] <= 1'b0;
                    if (rs_cap[i]) e_rs_vld[i] <= 1'b1;
                    if (rt_cap[i]) e_rt_vld[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (do_push && tail == PTR_W'(i)) begin
                e_st[i]      <= dispatch_is_store;
                e_imm[i]     <= dispatch_imm;
                e_rs_tag[i]  <= dispatch_rs_tag;
                e_rt_tag[i]  <= dispatch_rt_tag;
                e_rd_tag[i]  <= dispatch_rd_tag;
                e_rs_data[i] <= disp_rs_cap ? snoop_data : dispatch_rs_data;
                e_rt_data[i] <= disp_rt_cap ? snoop_data : dispatch_rt_data;
            end else begin
                if (rs_cap[i]) e_rs_data[i] <= snoop_data;
                if (rt_cap[i]) e_rt_data[i] <= snoop_data;
            end
        end
    end

    // Registered memory request and CDB result; payloads hold until their handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cdb_valid <= 1'b0;
            cdb_data  <= '0;
            cdb_tag   <= '0;
        end else if (flush) begin
            mem_req   <= 1'b0;
            cdb_valid <= 1'b0;
        end else begin
            if (do_issue) begin
                mem_req   <= 1'b1;
                mem_we    <= e_st[head];
                mem_addr  <= calc_addr(e_rs_data[head], e_imm[head]);
                mem_wdata <= e_rt_data[head];
            end else if (state == S_MEM && mem_ack) begin
                mem_req <= 1'b0;
            end
            if (do_load_done) begin
                cdb_valid <= 1'b1;
                cdb_data  <= mem_rdata;
                cdb_tag   <= e_rd_tag[head];
            end else if (state == S_CDB && cdb_grant) begin
                cdb_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_equeue_ls_fifo.sv
// Bench for equeue_ls_fifo: directed scenarios followed by random traffic, all checked
// against a transaction-level queue model of in-order issue with CDB operand capture.
module tb_equeue_ls_fifo;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, flush, dispatch_en, dispatch_is_store, dispatch_rsvalid, dispatch_rtvalid;
    logic [15:0]       dispatch_imm;
    logic [DATA_W-1:0] dispatch_rs_data, dispatch_rt_data, snoop_data, mem_rdata;
    logic [TAG_W-1:0]  dispatch_rs_tag, dispatch_rt_tag, dispatch_rd_tag, snoop_tag;
    logic              dispatch_ready, snoop_valid, mem_req, mem_we, mem_ack;
    logic [DATA_W-1:0] mem_addr, mem_wdata, cdb_data;
    logic              cdb_valid, cdb_grant, cdb_branch, cdb_branch_taken;
    logic [TAG_W-1:0]  cdb_tag;

    equeue_ls_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .dispatch_en(dispatch_en), .dispatch_is_store(dispatch_is_store),
        .dispatch_imm(dispatch_imm), .dispatch_rs_data(dispatch_rs_data),
        .dispatch_rs_tag(dispatch_rs_tag), .dispatch_rsvalid(dispatch_rsvalid),
        .dispatch_rt_data(dispatch_rt_data), .dispatch_rt_tag(dispatch_rt_tag),
        .dispatch_rtvalid(dispatch_rtvalid), .dispatch_rd_tag(dispatch_rd_tag),
        .dispatch_ready(dispatch_ready), .snoop_valid(snoop_valid), .snoop_tag(snoop_tag),
        .snoop_data(snoop_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .cdb_valid(cdb_valid), .cdb_data(cdb_data), .cdb_tag(cdb_tag), .cdb_grant(cdb_grant),
        .cdb_branch(cdb_branch), .cdb_branch_taken(cdb_branch_taken)
    );

    typedef struct {
        logic        st;
        logic [15:0] imm;
        logic [31:0] base;
        logic [5:0]  btag;
        logic        bv;
        logic [31:0] sd;
        logic [5:0]  stag;
        logic        sv;
        logic [5:0]  rd;
    } ent_t;

    ent_t        q[$];
    logic [31:0] exp_cdb_data;
    logic [5:0]  exp_cdb_tag;
    int          n_vec = 0;
    int          n_err = 0;
    int          n_cdb = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_addr(input ent_t e);
        int off;
        off = $signed(e.imm);
        return e.base + 32'(off);
    endfunction

    // One clock: advance the model with this cycle's inputs, take the edge, check outputs.
    task automatic tick();
        logic pre_rdy, pre_req, pre_cdbv;
        int   sz0;
        ent_t e;
        pre_req  = mem_req;
        pre_cdbv = cdb_valid;
        pre_rdy  = (q.size() > 0) && q[0].bv && (!q[0].st || q[0].sv);
        if (rst || flush) begin
            q.delete();
        end else begin
            sz0 = q.size();
            if (pre_req && mem_ack && q.size() > 0) begin
                if (q[0].st) q.pop_front();
                else begin
                    exp_cdb_data = mem_rdata;
                    exp_cdb_tag  = q[0].rd;
                end
            end
            if (pre_cdbv && cdb_grant && q.size() > 0) q.pop_front();
            if (dispatch_en && sz0 < DEPTH) begin
                e.st = dispatch_is_store;  e.imm = dispatch_imm;
                e.base = dispatch_rs_data; e.btag = dispatch_rs_tag; e.bv = dispatch_rsvalid;
                e.sd = dispatch_rt_data;   e.stag = dispatch_rt_tag; e.sv = dispatch_rtvalid;
                e.rd = dispatch_rd_tag;
                q.push_back(e);
            end
            if (snoop_valid) begin
                foreach (q[i]) begin
                    if (!q[i].bv && q[i].btag == snoop_tag) begin q[i].base = snoop_data; q[i].bv = 1'b1; end
                    if (!q[i].sv && q[i].stag == snoop_tag) begin q[i].sd = snoop_data; q[i].sv = 1'b1; end
                end
            end
        end
        @(posedge clk);
        #1;
        chk("dispatch_ready", dispatch_ready, q.size() != DEPTH);
        if (mem_req && !pre_req) begin
            chk("issue_operands_ready", pre_rdy, 1'b1);
            if (q.size() > 0) begin
                chk("mem_addr", mem_addr, ref_addr(q[0]));
                chk("mem_we", mem_we, q[0].st);
                if (q[0].st) chk("mem_wdata", mem_wdata, q[0].sd);
            end
        end
        if (cdb_valid && !pre_cdbv) begin
            n_cdb++;
            chk("cdb_data", cdb_data, exp_cdb_data);
            chk("cdb_tag", cdb_tag, exp_cdb_tag);
        end
        if (cdb_valid) chk("req_while_cdb", mem_req, 1'b0);
    endtask

    task automatic clear_in();
        dispatch_en = 1'b0; snoop_valid = 1'b0; mem_ack = 1'b0; cdb_grant = 1'b0; flush = 1'b0;
    endtask

    task automatic set_disp(input logic st, input logic [15:0] imm, input logic [31:0] rs,
                            input logic [5:0] rstag, input logic rsv, input logic [31:0] rt,
                            input logic [5:0] rttag, input logic rtv, input logic [5:0] rd);
        dispatch_en = 1'b1; dispatch_is_store = st; dispatch_imm = imm;
        dispatch_rs_data = rs; dispatch_rs_tag = rstag; dispatch_rsvalid = rsv;
        dispatch_rt_data = rt; dispatch_rt_tag = rttag; dispatch_rtvalid = rtv;
        dispatch_rd_tag = rd;
    endtask

    task automatic snoop(input logic [5:0] tag, input logic [31:0] data);
        snoop_valid = 1'b1; snoop_tag = tag; snoop_data = data;
    endtask

    // Memory and CDB always accept; optional random snoops release pending operands.
    task automatic drain(input int max_cycles, input logic rnd_snoop);
        for (int c = 0; c < max_cycles; c++) begin
            if (q.size() == 0 && !mem_req && !cdb_valid) break;
            clear_in();
            mem_ack   = mem_req;
            mem_rdata = $urandom;
            cdb_grant = cdb_valid;
            if (rnd_snoop) snoop(6'($urandom_range(1, 7)), $urandom);
            tick();
        end
        clear_in();
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        int c0;
        rst = 1'b1;
        clear_in();
        set_disp(0, 0, 0, 0, 0, 0, 0, 0, 0);
        dispatch_en = 1'b0;
        snoop_tag = '0; snoop_data = '0; mem_rdata = '0;
        exp_cdb_data = '0; exp_cdb_tag = '0;
        tick();
        tick();
        chk("rst_ready", dispatch_ready, 1'b1);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_cdb_valid", cdb_valid, 1'b0);
        chk("rst_cdb_data", cdb_data, 0);
        chk("rst_cdb_tag", cdb_tag, 0);
        chk("rst_cdb_branch", {cdb_branch, cdb_branch_taken}, 2'b00);
        rst = 1'b0;

        // Ready load with negative offset
        set_disp(0, 16'hFFFC, 32'h100, 0, 1, 0, 0, 0, 6'd5);
        tick(); clear_in();
        chk("t1_no_req_at_E", mem_req, 1'b0);
        tick();
        chk("t1_req", mem_req, 1'b1);
        chk("t1_addr", mem_addr, 32'hFC);
        chk("t1_we", mem_we, 1'b0);
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick(); clear_in();
        chk("t1_cdb_valid", cdb_valid, 1'b1);
        chk("t1_cdb_data", cdb_data, 32'hDEADBEEF);
        chk("t1_cdb_tag", cdb_tag, 6'd5);
        chk("t1_req_dropped", mem_req, 1'b0);
        cdb_grant = 1'b1;
        tick(); clear_in();
        chk("t1_cdb_clear", cdb_valid, 1'b0);
        tick();
        chk("t1_idle", mem_req, 1'b0);

        // Store waiting on its base from the CDB
        set_disp(1, 16'h0010, 0, 6'd9, 0, 32'h55, 0, 1, 0);
        tick(); clear_in();
        tick(); tick();
        chk("t2_wait", mem_req, 1'b0);
        snoop(6'd9, 32'h200);
        tick(); clear_in();
        chk("t2_no_req_at_snoop", mem_req, 1'b0);
        tick();
        chk("t2_req", mem_req, 1'b1);
        chk("t2_we", mem_we, 1'b1);
        chk("t2_addr", mem_addr, 32'h210);
        chk("t2_wdata", mem_wdata, 32'h55);
        mem_ack = 1'b1;
        tick(); clear_in();
        chk("t2_done_req", mem_req, 1'b0);
        tick();
        chk("t2_no_cdb", cdb_valid, 1'b0);

        // Fill past capacity, release in order, pointers wrap
        for (int i = 0; i <= DEPTH; i++) begin
            set_disp(0, 16'(i * 4), 0, 6'(10 + i), 0, 0, 0, 0, 6'(20 + i));
            tick(); clear_in();
            if (i == DEPTH - 1) chk("t3_full", dispatch_ready, 1'b0);
        end
        chk("t3_still_full", dispatch_ready, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            snoop(6'(10 + i), 32'(32'h1000 * (i + 1)));
            tick(); clear_in();
        end
        c0 = n_cdb;
        drain(200, 1'b0);
        chk("t3_completions", n_cdb - c0, DEPTH);
        snoop(6'(10 + DEPTH), 32'h9000);
        tick(); clear_in();
        tick(); tick();
        chk("t3_extra_dropped", mem_req, 1'b0);
        chk("t3_ready", dispatch_ready, 1'b1);

        // CDB backpressure with a second ready load queued behind
        set_disp(0, 16'h0004, 32'h40, 0, 1, 0, 0, 0, 6'd7);
        tick(); clear_in();
        tick();
        chk("t4_req", mem_req, 1'b1);
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        tick(); clear_in();
        set_disp(0, 16'h0000, 32'h80, 0, 1, 0, 0, 0, 6'd8);
        tick(); clear_in();
        for (int k = 0; k < 5; k++) begin
            chk("t4_hold_valid", cdb_valid, 1'b1);
            chk("t4_hold_data", cdb_data, 32'h12345678);
            chk("t4_hold_tag", cdb_tag, 6'd7);
            chk("t4_no_second_req", mem_req, 1'b0);
            tick();
        end
        cdb_grant = 1'b1;
        tick(); clear_in();
        chk("t4_granted", cdb_valid, 1'b0);
        chk("t4_gap", mem_req, 1'b0);
        tick();
        chk("t4_next_issue", mem_req, 1'b1);
        chk("t4_next_addr", mem_addr, 32'h80);
        drain(50, 1'b0);

        // Capture on the dispatch cycle; dispatch alongside pop at DEPTH-1
        set_disp(1, 16'h0008, 32'hBAD, 6'd33, 0, 32'h77, 0, 1, 0);
        snoop(6'd33, 32'h300);
        tick(); clear_in();
        chk("t5_no_early_req", mem_req, 1'b0);
        set_disp(0, 0, 0, 6'd40, 0, 0, 0, 0, 6'd50);
        tick(); clear_in();
        chk("t5_req", mem_req, 1'b1);
        chk("t5_captured_addr", mem_addr, 32'h308);
        set_disp(0, 0, 0, 6'd41, 0, 0, 0, 0, 6'd51);
        tick(); clear_in();
        set_disp(0, 0, 0, 6'd42, 0, 0, 0, 0, 6'd52);
        mem_ack = 1'b1;
        tick(); clear_in();
        chk("t5_count_unchanged", dispatch_ready, 1'b1);
        set_disp(0, 0, 0, 6'd43, 0, 0, 0, 0, 6'd53);
        tick(); clear_in();
        chk("t5_full", dispatch_ready, 1'b0);
        for (int t = 40; t < 44; t++) begin
            snoop(6'(t), 32'(t * 16));
            tick(); clear_in();
        end
        drain(200, 1'b0);

        // Flush while a load is in memory with three entries queued
        for (int i = 1; i <= 3; i++) begin
            set_disp(0, 0, 32'(16 * i), 0, 1, 0, 0, 0, 6'(i));
            tick(); clear_in();
        end
        chk("t6_in_mem", mem_req, 1'b1);
        flush = 1'b1;
        set_disp(0, 0, 32'h500, 0, 1, 0, 0, 0, 6'd4);
        tick(); clear_in();
        chk("t6_flush_req", mem_req, 1'b0);
        chk("t6_flush_cdb", cdb_valid, 1'b0);
        chk("t6_flush_ready", dispatch_ready, 1'b1);
        mem_ack = 1'b1; mem_rdata = 32'hFFFF0000;
        tick(); clear_in();
        chk("t6_late_ack_cdb", cdb_valid, 1'b0);
        tick(); tick();
        chk("t6_empty", mem_req, 1'b0);

        // Reset while a load result waits for the CDB
        set_disp(0, 0, 32'h20, 0, 1, 0, 0, 0, 6'd9);
        tick(); clear_in();
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick(); clear_in();
        chk("t6_in_cdb", cdb_valid, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_cdb_valid", cdb_valid, 1'b0);
        chk("t6_rst_cdb_data", cdb_data, 0);
        chk("t6_rst_cdb_tag", cdb_tag, 0);
        chk("t6_rst_req", mem_req, 1'b0);

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            clear_in();
            if ($urandom_range(0, 1) == 1)
                set_disp(1'($urandom), 16'($urandom), $urandom, 6'($urandom_range(1, 7)),
                         1'($urandom), $urandom, 6'($urandom_range(1, 7)), 1'($urandom),
                         6'($urandom));
            if ($urandom_range(0, 2) == 0) snoop(6'($urandom_range(1, 7)), $urandom);
            mem_ack   = mem_req && ($urandom_range(0, 2) != 0);
            mem_rdata = $urandom;
            cdb_grant = cdb_valid && ($urandom_range(0, 1) == 1);
            flush     = ($urandom_range(0, 99) == 0);
            tick();
        end
        drain(3000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/equeue_ls_fifo.md
Name: equeue_ls_fifo

Overview:
- Parametrised, in-order load/store issue queue for the Tomasulo back end.
- Accepts dispatched memory instructions and captures missing base/store-data operands by snooping the CDB.
- Issues the oldest entry to a single-port data memory once its operands are ready.
- Broadcasts load results on the CDB through a request/grant handshake. Replaces the fixed-ready load/store stub.

Parameters:
- DEPTH, 4, number of queue entries (power of two, ≥2)
- DATA_W, 32, operand/data/address width
- TAG_W, 6, ROB/physical tag width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  mispredict flush; discards all entries
- dispatch_en  in  1  dispatch valid
- dispatch_is_store  in  1  1=SW, 0=LW
- dispatch_imm  in  16  offset, sign-extended to DATA_W
- dispatch_rs_data  in  DATA_W  base value
- dispatch_rs_tag  in  TAG_W  base producer tag
- dispatch_rsvalid  in  1  base value valid
- dispatch_rt_data  in  DATA_W  store data
- dispatch_rt_tag  in  TAG_W  store-data producer tag
- dispatch_rtvalid  in  1  store data valid
- dispatch_rd_tag  in  TAG_W  destination tag (loads)
- dispatch_ready  out  1  queue can accept this cycle
- snoop_valid  in  1  CDB broadcast valid
- snoop_tag  in  TAG_W  CDB tag
- snoop_data  in  DATA_W  CDB data
- mem_req  out  1  memory request
- mem_we  out  1  write enable (store)
- mem_addr  out  DATA_W  byte address
- mem_wdata  out  DATA_W  store data
- mem_ack  in  1  memory completes request this cycle
- mem_rdata  in  DATA_W  load data, valid with mem_ack
- cdb_valid  out  1  load result request
- cdb_data  out  DATA_W  load result
- cdb_tag  out  TAG_W  load destination tag
- cdb_grant  in  1  CDB arbiter accepts result
- cdb_branch  out  1  tied 0
- cdb_branch_taken  out  1  tied 0

Behaviour:
- Storage: circular buffer with head/tail pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count of log2(DEPTH)+1 bits.
- dispatch_ready = (count != DEPTH). It is combinational and gives no same-cycle pop bypass.
- Write: the entry is written when dispatch_en && dispatch_ready. Dispatch while not ready is ignored.
- Snoop capture: every valid entry with a pending rs or rt whose tag == snoop_tag, with snoop_valid, captures snoop_data and sets its valid bit at the edge.
- Dispatch-cycle snoop: the entry being dispatched also captures a snoop match on its own rs/rt tags in the same cycle.
- The rt valid bit is ignored for loads.
- FSM states:
  - IDLE: go to MEM when count>0, head rs valid, and (load, or head rt valid).
  - MEM: on mem_ack, a store pops the head and goes to IDLE; a load latches mem_rdata and goes to CDB.
  - CDB: on cdb_grant, pop the head and go to IDLE.
- Registered outputs:
  - Entering MEM: mem_req=1; mem_addr = rs + sext(imm), truncated to DATA_W; mem_we = is_store; mem_wdata = rt.
  - These hold stable until mem_ack. Address alignment is not checked.
- Issue latency: an entry dispatched at edge E, already ready, gives mem_req=1 after edge E+1 at the earliest.
- Ack timing: a mem_ack in the same cycle as mem_req rise is legal.
- Load result:
  - mem_ack at edge A gives cdb_valid=1, cdb_data=rdata, cdb_tag=rd_tag after edge A.
  - cdb_valid and its payload hold until cdb_grant.
  - A grant at edge G clears cdb_valid and pops the entry. The next issue is possible after G+1.
- Store completion: stores never drive the CDB.
- Simultaneous dispatch and pop: count is unchanged and both pointers advance.
- Flush: at the next edge, count/head/tail=0, FSM IDLE, mem_req=0, cdb_valid=0.
  - An outstanding request is dropped; memory must tolerate mem_req falling without ack.
  - A store whose mem_ack coincides with flush is committed.
  - Dispatch in the flush cycle is discarded.
- Precedence: rst has priority over flush, and flush over all other events.
- Reset: all entries invalid, count=0, FSM IDLE. mem_req, mem_we, mem_addr, mem_wdata, cdb_valid, cdb_data, cdb_tag = 0. dispatch_ready=1, cdb_branch=cdb_branch_taken=0.

Test Plan:
- Ready load: dispatch LW rs=0x100 valid, imm=0xFFFC, rd_tag=5. Expect mem_req with addr=0xFC, we=0. Ack with rdata=0xDEADBEEF and grant next cycle. Expect cdb_valid with data 0xDEADBEEF, tag 5, one cycle, then count=0.
- Snooped base: dispatch SW rs pending on tag 9 and rt valid=0x55. Expect no mem_req. Then drive snoop tag 9 data 0x200. Expect mem_req, we=1, addr=0x200+imm, wdata=0x55. Ack pops the entry with no cdb_valid.
- Full/wrap: dispatch DEPTH+1 entries with operands pending. Expect dispatch_ready=0 after DEPTH, and the extra entry dropped. Release operands and complete all. Expect in-order completion and pointers wrapped; dispatch_ready=1.
- CDB backpressure: hold cdb_grant=0 for 5 cycles. Expect cdb_valid/data/tag stable and no second mem_req. Grant then causes a pop.
- Same-cycle snoop and dispatch, plus dispatch with pop when count=DEPTH-1 → count unchanged. Expect the captured value used in mem_addr.
- Flush while in MEM with 3 entries: expect after the next edge mem_req=0, count=0, dispatch_ready=1. A late mem_ack is ignored. rst mid-CDB clears cdb_valid.
